data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache_pkg.sv | 29 ++
 rtl/data_cache_array.sv | 52 +++++
 rtl/data_cache.sv | 177 +++++++++++++++++
 tb/tb_data_cache.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and line geometry for the direct-mapped data cache.
// Imported by the storage array and by the cache controller.
package data_cache_pkg;

  localparam int LINE_W = 128;
  localparam int WORDS  = 4;
  localparam int OFF_W  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOC_REQ,
    ALLOC_WAIT
  } state_t;

  function automatic logic [LINE_W-1:0] put_word(
    input logic [LINE_W-1:0] line,
    input logic [1:0]        w,
    input logic [WORD_W-1:0] d
  );
    logic [LINE_W-1:0] r;
    r = line;
    r[w*WORD_W +: WORD_W] = d;
    return r;
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Line storage: valid/dirty/tag/data per set.
// One full-line write port, combinational read at the same index.
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = 32 - OFF_W - IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  index,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  input  logic              we,
  input  logic              wr_valid,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we) begin
      valid_q[index] <= wr_valid;
      dirty_q[index] <= wr_dirty;
    end
  end

  // Tags and data are don't-care while the valid bit is clear.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[index]  <= wr_tag;
      data_q[index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[index];
  assign rd_dirty = dirty_q[index];
  assign rd_tag   = tag_q[index];
  assign rd_data  = data_q[index];

endmodule

// File: rtl/data_cache.sv
// Write-back, write-allocate direct-mapped data cache controller.
// Owns the miss FSM, the request registers and the hit/miss counters.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int NUM_SETS = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req_valid,
  output logic          cpu_ready,
  input  logic [31:0]   cpu_addr,
  input  logic          cpu_read,
  input  logic          cpu_write,
  input  logic [31:0]   cpu_din,
  output logic          cpu_resp_valid,
  output logic [31:0]   cpu_dout,
  output logic          cpu_hit,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_write,
  output logic [31:0]   mem_req_addr,
  output logic [127:0]  mem_req_data,
  input  logic          mem_resp_valid,
  input  logic [127:0]  mem_resp_data,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - OFF_W - IDX_W;

  state_t state_q, state_d;

  logic [31:2] addr_q;
  logic [31:0] din_q;
  logic        rd_q, wr_q, missed_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [1:0]        word;
  logic              nop, hit;

  logic              rd_valid, rd_dirty;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_data;
  logic              we, wr_valid, wr_dirty;
  logic [TAG_W-1:0]  wr_tag;
  logic [LINE_W-1:0] wr_data;

  wire unused_addr_bits = &{1'b0, cpu_addr[1:0]};

  assign idx  = addr_q[OFF_W +: IDX_W];
  assign tag  = addr_q[31 -: TAG_W];
  assign word = addr_q[3:2];
  assign nop  = !rd_q && !wr_q;
  assign hit  = rd_valid && (rd_tag == tag);

  data_cache_array #(
    .NUM_SETS (NUM_SETS)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .index    (idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (we),
    .wr_valid (wr_valid),
    .wr_dirty (wr_dirty),
    .wr_tag   (wr_tag),
    .wr_data  (wr_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      missed_q   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state_q <= state_d;
      if (cpu_req_valid && cpu_ready)
        missed_q <= 1'b0;
      else if (state_q == COMPARE && !nop && !hit)
        missed_q <= 1'b1;
      // Counted on completion, classified by the first lookup.
      if (state_q == COMPARE && !nop && hit) begin
        if (missed_q)
          miss_count <= miss_count + 32'd1;
        else
          hit_count <= hit_count + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_req_valid && cpu_ready) begin
      addr_q <= cpu_addr[31:2];
      din_q  <= cpu_din;
      rd_q   <= cpu_read;
      wr_q   <= cpu_write;
    end
  end

  always_comb begin
    state_d        = state_q;
    cpu_ready      = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_dout       = '0;
    cpu_hit        = 1'b0;
    mem_req_valid  = 1'b0;
    mem_req_write  = 1'b0;
    mem_req_addr   = '0;
    mem_req_data   = '0;
    we             = 1'b0;
    wr_valid       = rd_valid;
    wr_dirty       = rd_dirty;
    wr_tag         = rd_tag;
    wr_data        = rd_data;
    unique case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_req_valid)
          state_d = COMPARE;
      end
      COMPARE: begin
        if (nop) begin
          cpu_resp_valid = 1'b1;
          state_d        = IDLE;
        end else if (hit) begin
          cpu_resp_valid = 1'b1;
          cpu_hit        = !missed_q;
          state_d        = IDLE;
          if (wr_q) begin
            we       = 1'b1;
            wr_dirty = 1'b1;
            wr_data  = put_word(rd_data, word, din_q);
          end else begin
            cpu_dout = rd_data[word*WORD_W +: WORD_W];
          end
        end else if (rd_valid && rd_dirty) begin
          state_d = WRITEBACK;
        end else begin
          state_d = ALLOC_REQ;
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {rd_tag, idx, 4'b0};
        mem_req_data  = rd_data;
        if (mem_req_ready)
          state_d = ALLOC_REQ;
      end
      ALLOC_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {tag, idx, 4'b0};
        if (mem_req_ready)
          state_d = ALLOC_WAIT;
      end
      ALLOC_WAIT: begin
        if (mem_resp_valid) begin
          we       = 1'b1;
          wr_valid = 1'b1;
          wr_dirty = 1'b0;
          wr_tag   = tag;
          wr_data  = mem_resp_data;
          state_d  = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache with a response scoreboard
// and a small line-memory model on the memory port.
module tb_data_cache;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic         cpu_req_valid, cpu_ready;
  logic [31:0]  cpu_addr;
  logic         cpu_read, cpu_write;
  logic [31:0]  cpu_din;
  logic         cpu_resp_valid;
  logic [31:0]  cpu_dout;
  logic         cpu_hit;
  logic         mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_data;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
  logic [31:0]  hit_count, miss_count;

  always #5 clk = ~clk;

  data_cache #(.NUM_SETS(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_ready      (cpu_ready),
    .cpu_addr       (cpu_addr),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_din        (cpu_din),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_dout       (cpu_dout),
    .cpu_hit        (cpu_hit),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_write  (mem_req_write),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  typedef struct packed {
    logic         w;
    logic [31:0]  a;
    logic [127:0] d;
  } mreq_t;

  typedef struct {
    logic [31:0] dout;
    logic        hit;
    logic        chk_hit;
  } exp_t;

  mreq_t req_q[$];
  exp_t  exp_q[$];

  int checks = 0;
  int errors = 0;

  logic         mem_stall  = 1'b0;
  logic         spur       = 1'b0;
  logic [127:0] spur_data  = '0;
  logic         pend;
  int           cnt;
  logic [31:0]  pend_addr;

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [31:0] b;
    b = {a[31:4], 4'b0};
    return {(b + 32'd12) ^ K, (b + 32'd8) ^ K, (b + 32'd4) ^ K, b ^ K};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory model: accepts requests unless stalled, answers reads 3 cycles on.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    pend           = 1'b0;
    cnt            = 0;
    pend_addr      = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0;
        cnt  = 0;
      end
      mem_resp_valid = spur;
      mem_resp_data  = spur ? spur_data : '0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_line(pend_addr);
          pend           = 1'b0;
        end
      end
      mem_req_ready = !mem_stall;
      if (mem_req_valid && mem_req_ready) begin
        req_q.push_back('{mem_req_write, mem_req_addr, mem_req_data});
        if (!mem_req_write) begin
          pend      = 1'b1;
          cnt       = 3;
          pend_addr = mem_req_addr;
        end
      end
    end
  end

  task automatic issue(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic push, input logic [31:0] edout,
                       input logic ehit, input logic chkhit);
    chk("ready_at_issue", cpu_ready, 1);
    chk("dout_idle", cpu_dout, 0);
    cpu_req_valid = 1'b1;
    cpu_read      = rd;
    cpu_write     = wr;
    cpu_addr      = a;
    cpu_din       = d;
    if (push) exp_q.push_back('{edout, ehit, chkhit});
    @(negedge clk);
    cpu_req_valid = 1'b0;
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat);
    int   lat;
    exp_t e;
    lat = 1;
    while (!cpu_resp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("resp_valid", cpu_resp_valid, 1);
    chk("exp_pending", exp_q.size() != 0, 1);
    if (cpu_resp_valid && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("resp_dout", cpu_dout, e.dout);
      if (e.chk_hit) chk("resp_hit", cpu_hit, e.hit);
      if (exp_lat > 0) chk("resp_latency", lat, exp_lat);
    end
    @(negedge clk);
  endtask

  initial begin
    int           n;
    int           nreq;
    logic [127:0] line_v;
    logic [160:0] snap;
    mreq_t        r;

    reset         = 1'b1;
    cpu_req_valid = 1'b0;
    cpu_read      = 1'b0;
    cpu_write     = 1'b0;
    cpu_addr      = '0;
    cpu_din       = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_ready", cpu_ready, 1);
    chk("rst_resp", cpu_resp_valid, 0);
    chk("rst_memreq", mem_req_valid, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_misses", miss_count, 0);

    // Cold load miss
    line_v = mem_line(32'h100);
    issue(1, 0, 32'h100, 0, 1, line_v[31:0], 0, 1);
    wait_resp(0);
    chk("cold_nreq", req_q.size(), 1);
    r = req_q[0];
    chk("cold_req_w", r.w, 0);
    chk("cold_req_a", r.a, 32'h100);
    chk("cold_miss", miss_count, 1);
    chk("cold_hit", hit_count, 0);

    // Store hit, then load hit
    issue(0, 1, 32'h104, 32'hDEADBEEF, 1, 0, 1, 1);
    wait_resp(1);
    issue(1, 0, 32'h104, 0, 1, 32'hDEADBEEF, 1, 1);
    wait_resp(1);
    chk("hit_nreq", req_q.size(), 1);
    chk("hit_hits", hit_count, 2);

    // Dirty victim writeback with memory stalled
    mem_stall = 1'b1;
    @(negedge clk);
    line_v = mem_line(32'h1100);
    issue(1, 0, 32'h1104, 0, 1, line_v[63:32], 0, 1);
    n = 0;
    while (!mem_req_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wb_seen", mem_req_valid, 1);
    chk("wb_write", mem_req_write, 1);
    chk("wb_addr", mem_req_addr, 32'h100);
    chk("wb_word1", mem_req_data[63:32], 32'hDEADBEEF);
    chk("wb_word0", mem_req_data[31:0], 32'h100 ^ K);
    snap = {mem_req_write, mem_req_addr, mem_req_data};
    repeat (5) begin
      @(negedge clk);
      chk("wb_stable", {mem_req_valid, mem_req_write, mem_req_addr, mem_req_data},
          {1'b1, snap});
      chk("wb_ready_low", cpu_ready, 0);
    end
    mem_stall = 1'b0;
    wait_resp(0);
    chk("wb_nreq", req_q.size(), 3);
    r = req_q[1];
    chk("wb_log_w", r.w, 1);
    chk("wb_log_a", r.a, 32'h100);
    chk("wb_log_d", r.d[63:32], 32'hDEADBEEF);
    r = req_q[2];
    chk("refill_w", r.w, 0);
    chk("refill_a", r.a, 32'h1100);
    chk("wb_misses", miss_count, 2);

    // Reset while waiting for a refill
    issue(1, 0, 32'h200, 0, 0, 0, 0, 0);
    n = 0;
    while (!(mem_req_valid && !mem_req_write) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("alloc_seen", mem_req_valid, 1);
    @(negedge clk);
    chk("alloc_wait_idle", {mem_req_valid, cpu_ready}, 2'b00);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst2_ready", cpu_ready, 1);
    chk("rst2_hits", hit_count, 0);
    chk("rst2_misses", miss_count, 0);
    nreq = req_q.size();
    line_v = mem_line(32'h100);
    issue(1, 0, 32'h100, 0, 1, line_v[31:0], 0, 1);
    wait_resp(0);
    chk("rst2_nreq", req_q.size(), nreq + 1);
    r = req_q[nreq];
    chk("rst2_req_w", r.w, 0);
    chk("rst2_req_a", r.a, 32'h100);
    chk("rst2_misses_after", miss_count, 1);
    chk("rst2_hits_after", hit_count, 0);

    // Spurious refill while idle must not install a line
    spur_data = {$urandom, $urandom, $urandom, $urandom};
    spur = 1'b1;
    repeat (2) @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    line_v = mem_line(32'h10);
    issue(1, 0, 32'h14, 0, 1, line_v[63:32], 0, 1);
    wait_resp(0);
    chk("spur_misses", miss_count, 2);
    r = req_q[req_q.size() - 1];
    chk("spur_req_a", r.a, 32'h10);

    // Read+write together behaves as a store
    issue(1, 1, 32'h18, 32'h12345678, 1, 0, 1, 1);
    wait_resp(1);
    issue(1, 0, 32'h18, 0, 1, 32'h12345678, 1, 1);
    wait_resp(1);
    chk("rw_hits", hit_count, 2);

    // Neither read nor write: completes without touching counters
    issue(0, 0, 32'h14, 0, 1, 0, 0, 0);
    wait_resp(1);
    chk("nop_hits", hit_count, 2);
    chk("nop_misses", miss_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
